// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and defaults for the parametrised sync FIFO
package fifo_pkg;
  localparam int DEF_DWIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  typedef logic [ptr_w(DEF_DEPTH)-1:0] count_t;
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: unreset register array, synchronous write port and asynchronous read port
module fifo_mem_2p #(
  parameter int DWIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DWIDTH-1:0]        rdata
);
  logic [DWIDTH-1:0] mem_q [DEPTH];
  // store the accepted write word
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, threshold flags and sticky errors; SYNC_FIFO_FWFT_EN selects first-word fall-through
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          datain,
  input  logic                       w_en,
  input  logic                       r_en,
  output logic [DWIDTH-1:0]          dataout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ptr_w(DEPTH)-1:0]    count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] FULL_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic ovf_q, ovf_d, udf_q, udf_d, wr_acc, rd_acc;
  logic [DWIDTH-1:0] rdata;
  fifo_mem_2p #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(wr_acc), .waddr(wr_ptr_q[AW-1:0]), .wdata(datain),
    .raddr(rd_ptr_q[AW-1:0]), .rdata(rdata)
  );
  assign full = count_q == FULL_L;
  assign empty = count_q == '0;
  assign almost_full = count_q >= AF_L;
  assign almost_empty = count_q <= AE_L;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = udf_q;
  // accept/reject requests and compute next pointers, count and sticky errors
  always_comb begin
    wr_acc = w_en & ~full;
    rd_acc = r_en & ~empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (wr_acc & ~rd_acc) ? count_q + 1'b1 : (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
    ovf_d = ovf_q | (w_en & full);
    udf_d = udf_q | (r_en & empty);
  end
  // pointer, count and error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign dataout = empty ? '0 : rdata;
`else
  logic [DWIDTH-1:0] dout_q, dout_d;
  // output register loads the head word only on an accepted read
  always_comb begin
    dout_d = rd_acc ? rdata : dout_q;
  end
  // registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else dout_q <= dout_d;
  end
  assign dataout = dout_q;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table-driven directed checks of sync_fifo_param (DWIDTH=8, DEPTH=16)
module tb_sync_fifo_param;
  logic clk = 1'b0, rst = 1'b1, w_en = 1'b0, r_en = 1'b0;
  logic [7:0] datain = '0, dataout;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst, w, r;
    logic [7:0] din, dout;
    logic [4:0] cnt;
    logic [5:0] fl;
  } vec_t;
  vec_t v[$];
  sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .datain(datain), .w_en(w_en), .r_en(r_en), .dataout(dataout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] fl(input int c, input bit o, input bit u);
    return {c == 16, c == 0, c >= 14, c <= 2, o, u};
  endfunction
  task automatic add(input bit r0, input bit w, input bit r, input int din, input int dout, input int c, input bit o, input bit u);
    vec_t e;
    e.rst = r0; e.w = w; e.r = r; e.din = 8'(din); e.dout = 8'(dout); e.cnt = 5'(c); e.fl = fl(c, o, u);
    v.push_back(e);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) add(0, 1, 0, k, 0, k, 0, 0);
    add(0, 1, 0, 'hAA, 0, 16, 1, 0);
    for (int k = 1; k <= 16; k++) add(0, 0, 1, 0, k, 16 - k, 1, 0);
    add(0, 0, 1, 0, 16, 0, 1, 1);
    add(0, 1, 0, 'h5C, 16, 1, 1, 1);
    add(0, 0, 1, 0, 'h5C, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 'h20 + i, 0, i + 1, 0, 0);
    for (int j = 0; j < 20; j++) add(0, 1, 1, 'h28 + j, 'h20 + j, 8, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 0, 1, 0, 'h34 + k, 7 - k, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 'h40 + i, 0, i + 1, 0, 0);
    add(0, 1, 1, 'hEE, 'h40, 15, 1, 0);
    for (int k = 1; k <= 15; k++) add(0, 0, 1, 0, 'h40 + k, 15 - k, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 'h77, 0, 1, 0, 1);
    add(0, 0, 1, 0, 'h77, 0, 0, 1);
    foreach (v[i]) begin
      rst = v[i].rst; w_en = v[i].w; r_en = v[i].r; datain = v[i].din;
      cycle();
      check($sformatf("v%0d count", i), 32'(count), 32'(v[i].cnt));
      check($sformatf("v%0d flags", i), 32'({full, empty, almost_full, almost_empty, overflow, underflow}), 32'(v[i].fl));
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("v%0d dataout", i), 32'(dataout), 32'(v[i].dout));
`endif
    end
    rst = 1'b0; w_en = 1'b1; r_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      datain = 8'(8'h60 + i);
      cycle();
    end
    check("midrst pre count", 32'(count), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("midrst async count", 32'(count), 32'd0);
    check("midrst async flags", 32'({full, empty, almost_full, almost_empty, overflow, underflow}), 32'(6'b010100));
    check("midrst async dataout", 32'(dataout), 32'd0);
    @(negedge clk);
    rst = 1'b0; datain = 8'h3E; w_en = 1'b1;
    cycle();
    w_en = 1'b0;
    check("post rst write count", 32'(count), 32'd1);
    check("post rst empty", 32'(empty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft dataout before read", 32'(dataout), 32'h3E);
`endif
    r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    check("post rst read count", 32'(count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("post rst read dataout", 32'(dataout), 32'h3E);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
